// File: rtl/rv_shift_arb.sv
// Two-requester round-robin arbiter in front of a single 32-bit shifter,
// with a one-deep registered result slot and valid/ready handshakes.

package rv_shift_pkg;
   typedef enum logic [1:0] {
      ALU_SLL = 2'd0,
      ALU_SRL = 2'd1,
      ALU_SRA = 2'd2
   } shift_op_e;
endpackage

// Shifter: every operation is done as a right shift; left shifts take the
// bit-reversed operand and reverse the result back.
module rv_shift
   import rv_shift_pkg::*;
(
   input  shift_op_e   op,
   input  logic [31:0] a,
   input  logic [4:0]  amt,
   input  logic [31:0] op_a_rev,
   output logic [31:0] res
);

   logic [31:0] src;
   logic        fill;
   logic [63:0] ext_sh;
   logic [31:0] sh;

   // Select source and fill bit, right shift, un-reverse for left shifts
   always_comb begin
      src    = (op == ALU_SLL) ? op_a_rev : a;
      fill   = (op == ALU_SRA) & a[31];
      ext_sh = {{32{fill}}, src} >> amt;
      sh     = ext_sh[31:0];
      res    = sh;
      if (op == ALU_SLL) begin
         for (int unsigned i = 0; i < 32; i++) begin
            res[i] = sh[31 - i];
         end
      end
   end

endmodule

module rv_shift_arb
   import rv_shift_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  shift_op_e   req0_op,
   input  logic [31:0] req0_a,
   input  logic [4:0]  req0_amt,
   input  logic [3:0]  req0_tag,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  shift_op_e   req1_op,
   input  logic [31:0] req1_a,
   input  logic [4:0]  req1_amt,
   input  logic [3:0]  req1_tag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_id,
   output logic [3:0]  out_tag
);

   logic        rr_ptr;
   logic        accept_en;
   logic        grant0;
   logic        grant1;
   logic        xfer;
   shift_op_e   sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_a_rev;
   logic [4:0]  sel_amt;
   logic [3:0]  sel_tag;
   logic [31:0] shift_res;

   // Arbitration, handshake and operand selection
   always_comb begin
      accept_en  = !out_valid | out_ready;
      grant1     = req1_valid & (!req0_valid | rr_ptr);
      grant0     = req0_valid & (!req1_valid | !rr_ptr);
      // rst_n gating keeps both readies low while reset is held
      req0_ready = rst_n & accept_en & grant0;
      req1_ready = rst_n & accept_en & grant1;
      xfer       = req0_ready | req1_ready;
      sel_op     = grant1 ? req1_op  : req0_op;
      sel_a      = grant1 ? req1_a   : req0_a;
      sel_amt    = grant1 ? req1_amt : req0_amt;
      sel_tag    = grant1 ? req1_tag : req0_tag;
      sel_a_rev  = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         sel_a_rev[i] = sel_a[31 - i];
      end
   end

   rv_shift u_shift (
      .op       (sel_op),
      .a        (sel_a),
      .amt      (sel_amt),
      .op_a_rev (sel_a_rev),
      .res      (shift_res)
   );

   // Result slot and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         out_id    <= 1'b0;
         out_tag   <= '0;
         rr_ptr    <= 1'b0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_res   <= shift_res;
            out_id    <= grant1;
            out_tag   <= sel_tag;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (xfer && req0_valid && req1_valid) begin
            rr_ptr <= !grant1;
         end
      end
   end

endmodule

// File: doc/rv_shift_arb.md
RV_SHIFT_ARB -- requirements
Module: rv_shift_arb

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1, requester 0/1 holds a shift request.
REQ-004 SHALL have ports req0_ready / req1_ready, output, 1, request accepted this cycle when valid&ready.
REQ-005 SHALL have ports req0_op / req1_op, input, shift_op_e, shift operation (ALU_SLL, ALU_SRL, ALU_SRA).
REQ-006 SHALL have ports req0_a / req1_a, input, 32, operand to shift.
REQ-007 SHALL have ports req0_amt / req1_amt, input, 5, shift amount.
REQ-008 SHALL have ports req0_tag / req1_tag, input, 4, requester tag returned with the result.
REQ-009 SHALL have port out_valid, output, 1, result register holds a valid result.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result when out_valid&out_ready.
REQ-011 SHALL have ports out_res (32), out_id (1, winning requester), out_tag (4), outputs, result fields.

Function
REQ-012 SHALL instantiate exactly one rv_shift, feeding the granted request's op, a, amt, plus internally generated bit-reversed a as op_a_rev.
REQ-013 SHALL compute shifts as: ALU_SLL logical left; ALU_SRA arithmetic right; any other op logical right; amt taken modulo 32.
REQ-014 SHALL define accept_en = !out_valid | out_ready (output slot empty or draining this cycle).
REQ-015 SHALL grant, when only one requester is valid, that requester; when both valid, the one indicated by 1-bit round-robin pointer rr_ptr.
REQ-016 SHALL drive reqN_ready = accept_en & grantN, combinationally; at most one ready high per cycle; ready independent of the loser's valid otherwise.
REQ-017 SHALL toggle rr_ptr to the non-granted requester only on a cycle where both were valid and a transfer occurred; otherwise rr_ptr holds.
REQ-018 SHALL, on a transfer, register out_res, out_id, out_tag and set out_valid=1 on the next edge (latency exactly 1 cycle).
REQ-019 SHALL clear out_valid on an edge where out_valid&out_ready and no new transfer occurs.
REQ-020 SHALL, on simultaneous drain and new transfer, load the new result with out_valid staying 1 (full throughput, one result per cycle).
REQ-021 SHALL hold out_res, out_id, out_tag stable while out_valid=1 and out_ready=0.
REQ-022 SHALL tolerate requesters changing op/a/amt/tag while not accepted; only values sampled on the transfer cycle matter.

Reset
REQ-023 SHALL, while rst_n=0, force out_valid=0, out_res=0, out_id=0, out_tag=0, rr_ptr=0 (requester 0 favoured), regardless of clk.
REQ-024 SHALL, on reset asserted mid-operation, discard the held result; no result reappears after deassertion.
REQ-025 SHALL keep req0_ready/req1_ready low during reset.

Verification
REQ-026 Single req0 ALU_SLL a=0x0000_0001 amt=31 tag=3, out_ready=1 -> next cycle out_valid=1, out_res=0x8000_0000, out_id=0, out_tag=3.
REQ-027 req1 ALU_SRA a=0x8000_0000 amt=4, then ALU_SRL same operand -> out_res 0xF800_0000 then 0x0800_0000, back-to-back cycles.
REQ-028 Both valid continuously for 4 cycles after reset, out_ready=1 -> grants 0,1,0,1; out_id follows one cycle later.
REQ-029 out_ready=0 with out_valid=1 for 3 cycles, both requesters valid -> both ready low, outputs unchanged; out_ready=1 -> next grant goes to rr_ptr requester.
REQ-030 Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid falls immediately, all outputs 0, rr_ptr=0 after release.
REQ-031 Random stimulus: every accepted request yields exactly one result in order with result matching reference shift model and correct id/tag.
